// File: rtl/unary_add_sched.sv
// Purpose : round-robin share of one external unary adder between NREQ requesters.
// Latency : 1 + max(a,b) + (sum+2) + 1 cycles from request seen in IDLE to rsp_valid.
// Backpres: requesters hold req and operands until rsp_valid; later requests wait.
//
// Ports
//   clk, rst_n          : clock (rising edge) and asynchronous active-low reset
//   req                 : per-requester request, held until the matching response
//   op_a, op_b          : packed binary operands, requester i at [i*W +: W]
//   gnt                 : one-hot grant while the adder is working for a requester
//   busy                : high whenever the scheduler is not idle
//   rsp_valid           : one-cycle response strobe
//   rsp_id, rsp_sum,
//   rsp_carry           : answered requester, (a+b) mod (LEN+1), and a+b > LEN
//   add_en, add_rw,
//   add_a, add_b        : registered controls to the shared adder
//   add_dout, add_c     : unary drain output and carry from the shared adder

module unary_add_sched #(
    parameter int NREQ = 4,
    parameter int LEN  = 16,
    parameter int W    = 5,
    parameter int IW   = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NREQ-1:0]   req,
    input  logic [NREQ*W-1:0] op_a,
    input  logic [NREQ*W-1:0] op_b,
    output logic [NREQ-1:0]   gnt,
    output logic              busy,
    output logic              rsp_valid,
    output logic [IW-1:0]     rsp_id,
    output logic [W-1:0]      rsp_sum,
    output logic              rsp_carry,
    output logic              add_en,
    output logic              add_rw,
    output logic              add_a,
    output logic              add_b,
    input  logic              add_dout,
    input  logic              add_c
);

    localparam logic [W-1:0]  LEN_W    = W'(LEN);
    localparam logic [IW-1:0] LAST_IDX = IW'(NREQ - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        WRITE = 2'd2,
        RESP  = 2'd3
    } state_t;

    // Index base+off folded back into 0..NREQ-1 (off < NREQ).
    function automatic logic [IW-1:0] wrap_idx(input logic [IW-1:0] base, input int off);
        int t;
        t = int'(base) + off;
        if (t >= NREQ) begin
            t = t - NREQ;
        end
        return IW'(t);
    endfunction

    // Operands above LEN saturate to LEN.
    function automatic logic [W-1:0] sat(input logic [W-1:0] v);
        return (v > LEN_W) ? LEN_W : v;
    endfunction

    // ------------------------------------------------------------------
    // Transaction state
    // ------------------------------------------------------------------
    state_t        state,  state_nx;
    logic [W-1:0]  k,      k_nx;       // read-phase cycle counter
    logic [W-1:0]  a_r,    a_nx;       // saturated operand A
    logic [W-1:0]  b_r,    b_nx;       // saturated operand B
    logic [W-1:0]  mx,     mx_nx;      // read-phase length, max(a,b)
    logic [W-1:0]  n,      n_nx;       // ones seen on add_dout
    logic          flag,   flag_nx;    // sticky carry
    logic          wfirst, wfirst_nx;  // first cycle of the drain phase
    logic [IW-1:0] idx,    idx_nx;     // granted requester
    logic [IW-1:0] rr,     rr_nx;      // round-robin start point

    // Next values of the registered outputs
    logic [NREQ-1:0] gnt_nx;
    logic            busy_nx;
    logic            rsp_valid_nx;
    logic [IW-1:0]   rsp_id_nx;
    logic [W-1:0]    rsp_sum_nx;
    logic            rsp_carry_nx;
    logic            add_en_nx;
    logic            add_rw_nx;
    logic            add_a_nx;
    logic            add_b_nx;

    // Arbitration
    logic            pick_vld;
    logic [IW-1:0]   pick;
    logic [W-1:0]    op_a_sel;
    logic [W-1:0]    op_b_sel;

    // Scan from the highest offset down so the lowest offset from rr wins.
    always_comb begin
        pick_vld = 1'b0;
        pick     = '0;
        for (int j = NREQ - 1; j >= 0; j--) begin
            if (req[wrap_idx(rr, j)]) begin
                pick_vld = 1'b1;
                pick     = wrap_idx(rr, j);
            end
        end
    end

    assign op_a_sel = op_a[int'(pick) * W +: W];
    assign op_b_sel = op_b[int'(pick) * W +: W];

    // ------------------------------------------------------------------
    // Next-state logic. The adder controls and response outputs are
    // derived from the next state so they can be registered and still
    // line up with the state they belong to.
    // ------------------------------------------------------------------
    always_comb begin
        state_nx  = state;
        k_nx      = k;
        a_nx      = a_r;
        b_nx      = b_r;
        mx_nx     = mx;
        n_nx      = n;
        flag_nx   = flag;
        wfirst_nx = wfirst;
        idx_nx    = idx;
        rr_nx     = rr;

        case (state)
            IDLE: begin
                if (pick_vld) begin
                    idx_nx    = pick;
                    a_nx      = sat(op_a_sel);
                    b_nx      = sat(op_b_sel);
                    mx_nx     = (a_nx > b_nx) ? a_nx : b_nx;
                    k_nx      = '0;
                    n_nx      = '0;
                    flag_nx   = 1'b0;
                    wfirst_nx = 1'b1;
                    // Nothing to feed when both operands are zero.
                    state_nx  = (mx_nx == '0) ? WRITE : LOAD;
                end
            end
            LOAD: begin
                flag_nx = flag | add_c;
                k_nx    = k + 1'b1;
                if (k_nx == mx) begin
                    state_nx = WRITE;
                end
            end
            WRITE: begin
                if (wfirst) begin
                    // Carry from the final read edge only shows up now;
                    // add_dout is still the read-phase zero.
                    flag_nx   = flag | add_c;
                    wfirst_nx = 1'b0;
                end else if (add_dout) begin
                    n_nx = n + 1'b1;
                end else begin
                    // First zero after the run of ones: adder is empty.
                    state_nx = RESP;
                end
            end
            RESP: begin
                rr_nx    = (idx == LAST_IDX) ? '0 : idx + 1'b1;
                state_nx = IDLE;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase

        add_en_nx = (state_nx == LOAD) || (state_nx == WRITE);
        add_rw_nx = (state_nx == WRITE);
        add_a_nx  = (state_nx == LOAD) && (k_nx < a_nx);
        add_b_nx  = (state_nx == LOAD) && (k_nx < b_nx);

        gnt_nx = '0;
        if ((state_nx == LOAD) || (state_nx == WRITE)) begin
            gnt_nx[idx_nx] = 1'b1;
        end

        busy_nx      = (state_nx != IDLE);
        rsp_valid_nx = (state_nx == RESP);
        rsp_id_nx    = (state_nx == RESP) ? idx_nx  : '0;
        rsp_sum_nx   = (state_nx == RESP) ? n_nx    : '0;
        rsp_carry_nx = (state_nx == RESP) ? flag_nx : 1'b0;
    end

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            k      <= '0;
            a_r    <= '0;
            b_r    <= '0;
            mx     <= '0;
            n      <= '0;
            flag   <= 1'b0;
            wfirst <= 1'b0;
            idx    <= '0;
            rr     <= '0;
        end else begin
            state  <= state_nx;
            k      <= k_nx;
            a_r    <= a_nx;
            b_r    <= b_nx;
            mx     <= mx_nx;
            n      <= n_nx;
            flag   <= flag_nx;
            wfirst <= wfirst_nx;
            idx    <= idx_nx;
            rr     <= rr_nx;
        end
    end

    // ------------------------------------------------------------------
    // Output registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gnt       <= '0;
            busy      <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_id    <= '0;
            rsp_sum   <= '0;
            rsp_carry <= 1'b0;
            add_en    <= 1'b0;
            add_rw    <= 1'b0;
            add_a     <= 1'b0;
            add_b     <= 1'b0;
        end else begin
            gnt       <= gnt_nx;
            busy      <= busy_nx;
            rsp_valid <= rsp_valid_nx;
            rsp_id    <= rsp_id_nx;
            rsp_sum   <= rsp_sum_nx;
            rsp_carry <= rsp_carry_nx;
            add_en    <= add_en_nx;
            add_rw    <= add_rw_nx;
            add_a     <= add_a_nx;
            add_b     <= add_b_nx;
        end
    end

endmodule

// File: tb/tb_unary_add_sched.sv
// Purpose : self-checking bench for unary_add_sched with a behavioural unary adder.
// Latency : responses checked against 1 + max(a,b) + (sum+2) + 1 cycles.
// Backpres: requests are held until their response, as the requester protocol demands.

module tb_unary_add_sched;

    localparam int NREQ = 4;
    localparam int LEN  = 16;
    localparam int W    = 5;
    localparam int IW   = 2;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [NREQ-1:0]   req = '0;
    logic [NREQ*W-1:0] op_a = '0;
    logic [NREQ*W-1:0] op_b = '0;
    logic [NREQ-1:0]   gnt;
    logic              busy;
    logic              rsp_valid;
    logic [IW-1:0]     rsp_id;
    logic [W-1:0]      rsp_sum;
    logic              rsp_carry;
    logic              add_en;
    logic              add_rw;
    logic              add_a;
    logic              add_b;
    logic              add_dout;
    logic              add_c;

    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    unary_add_sched #(.NREQ(NREQ), .LEN(LEN), .W(W), .IW(IW)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .op_a(op_a), .op_b(op_b),
        .gnt(gnt), .busy(busy), .rsp_valid(rsp_valid), .rsp_id(rsp_id),
        .rsp_sum(rsp_sum), .rsp_carry(rsp_carry), .add_en(add_en), .add_rw(add_rw),
        .add_a(add_a), .add_b(add_b), .add_dout(add_dout), .add_c(add_c)
    );

    // Stand-in for the shared unary adder: a mod-(LEN+1) ones counter that
    // accumulates A+B on read edges (C flags a wrap) and emits one 1 per
    // write edge until empty.
    int acc;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc <= 0; add_dout <= 1'b0; add_c <= 1'b0;
        end else if (add_en && !add_rw) begin
            add_dout <= 1'b0;
            if (acc + int'(add_a) + int'(add_b) > LEN) begin
                acc <= acc + int'(add_a) + int'(add_b) - (LEN + 1); add_c <= 1'b1;
            end else begin
                acc <= acc + int'(add_a) + int'(add_b); add_c <= 1'b0;
            end
        end else if (add_en) begin
            add_c <= 1'b0;
            add_dout <= (acc > 0);
            if (acc > 0) acc <= acc - 1;
        end else begin
            add_c <= 1'b0; add_dout <= 1'b0;
        end
    end

    // Reference model: plain arithmetic on saturated operands.
    function automatic int satv(int v);
        return (v > LEN) ? LEN : v;
    endfunction
    function automatic int ref_sum(int a, int b);
        return (satv(a) + satv(b)) % (LEN + 1);
    endfunction
    function automatic int ref_carry(int a, int b);
        return (satv(a) + satv(b) > LEN) ? 1 : 0;
    endfunction
    function automatic int ref_lat(int a, int b);
        int m;
        m = (satv(a) > satv(b)) ? satv(a) : satv(b);
        return 1 + m + (ref_sum(a, b) + 2) + 1;
    endfunction

    task automatic apply_reset();
        rst_n = 1'b0; req = '0;
        repeat (2) @(posedge clk);
        @(negedge clk); rst_n = 1'b1;
    endtask

    // Drive one request from an idle scheduler and record what comes back.
    task automatic do_txn(input int id, input int a, input int b,
                          output int cyc, output int ones, output int rid,
                          output int rsum, output int rcar, output int en_rsp,
                          output int acc_rsp, output int gnt_or, output int bad_gnt);
        @(posedge clk); #1;
        op_a[id*W +: W] = W'(a);
        op_b[id*W +: W] = W'(b);
        req[id] = 1'b1;
        cyc = 1; ones = 0; rid = -1; rsum = -1; rcar = -1; en_rsp = -1; acc_rsp = -1;
        gnt_or = 0; bad_gnt = 0;
        while (rid < 0 && cyc < 200) begin
            @(posedge clk); #1; cyc++;
            if (add_dout) ones++;
            if (!$onehot0(gnt)) bad_gnt = 1;
            gnt_or |= int'(gnt);
            if (rsp_valid) begin
                rid = int'(rsp_id); rsum = int'(rsp_sum); rcar = int'(rsp_carry);
                en_rsp = int'(add_en); acc_rsp = acc;
                req[id] = 1'b0;
            end
        end
        req[id] = 1'b0;
    endtask

    task automatic test_reset();
        logic [16:0] outs;
        rst_n = 1'b0; req = '0;
        repeat (3) @(posedge clk); #1;
        outs = {gnt, busy, rsp_valid, rsp_id, rsp_sum, rsp_carry, add_en, add_rw, add_a, add_b};
        total++; if (outs !== '0) $display("FAIL reset_outputs got=%h exp=0", outs); else passed++;
        @(negedge clk); rst_n = 1'b1;
        repeat (2) @(posedge clk); #1;
        outs = {gnt, busy, rsp_valid, rsp_id, rsp_sum, rsp_carry, add_en, add_rw, add_a, add_b};
        total++; if (outs !== '0) $display("FAIL idle_outputs got=%h exp=0", outs); else passed++;
    endtask

    task automatic test_single();
        int cyc, ones, rid, rsum, rcar, en_rsp, acc_rsp, gnt_or, bad_gnt;
        do_txn(0, 5, 7, cyc, ones, rid, rsum, rcar, en_rsp, acc_rsp, gnt_or, bad_gnt);
        total++; if (rid !== 0)  $display("FAIL single_id got=%0d exp=0", rid); else passed++;
        total++; if (rsum !== 12) $display("FAIL single_sum got=%0d exp=12", rsum); else passed++;
        total++; if (rcar !== 0) $display("FAIL single_carry got=%0d exp=0", rcar); else passed++;
        total++; if (cyc !== 23) $display("FAIL single_latency got=%0d exp=23", cyc); else passed++;
        total++; if (ones !== 12) $display("FAIL single_dout_ones got=%0d exp=12", ones); else passed++;
        total++; if (gnt_or !== 1) $display("FAIL single_gnt got=%0h exp=1", gnt_or); else passed++;
        total++; if (bad_gnt !== 0) $display("FAIL single_gnt_onehot got=%0d exp=0", bad_gnt); else passed++;
    endtask

    task automatic test_vectors();
        int tid[6] = '{1, 2, 3, 0, 1, 2};
        int ta[6]  = '{10, 16, 16, 0, 20, 0};
        int tb[6]  = '{9, 16, 1, 0, 0, 31};
        int cyc, ones, rid, rsum, rcar, en_rsp, acc_rsp, gnt_or, bad_gnt;
        for (int t = 0; t < 6; t++) begin
            do_txn(tid[t], ta[t], tb[t], cyc, ones, rid, rsum, rcar, en_rsp, acc_rsp, gnt_or, bad_gnt);
            total++; if (rid !== tid[t]) $display("FAIL vec%0d_id got=%0d exp=%0d", t, rid, tid[t]); else passed++;
            total++; if (rsum !== ref_sum(ta[t], tb[t])) $display("FAIL vec%0d_sum got=%0d exp=%0d", t, rsum, ref_sum(ta[t], tb[t])); else passed++;
            total++; if (rcar !== ref_carry(ta[t], tb[t])) $display("FAIL vec%0d_carry got=%0d exp=%0d", t, rcar, ref_carry(ta[t], tb[t])); else passed++;
            total++; if (cyc !== ref_lat(ta[t], tb[t])) $display("FAIL vec%0d_latency got=%0d exp=%0d", t, cyc, ref_lat(ta[t], tb[t])); else passed++;
            total++; if (gnt_or !== (1 << tid[t])) $display("FAIL vec%0d_gnt got=%0h exp=%0h", t, gnt_or, 1 << tid[t]); else passed++;
        end
    endtask

    // All four request together after reset (rr=0); requester 0 comes back
    // once requester 1 has been answered, while 2 and 3 are still waiting.
    task automatic test_simultaneous();
        int oa[NREQ], ob[NREQ];
        int pend[NREQ];
        int rr_m, nresp, exp_id, cyc, bad_gnt;
        apply_reset();
        @(posedge clk); #1;
        for (int i = 0; i < NREQ; i++) begin
            oa[i] = $urandom_range(0, LEN); ob[i] = $urandom_range(0, LEN);
            op_a[i*W +: W] = W'(oa[i]); op_b[i*W +: W] = W'(ob[i]);
            pend[i] = 1;
        end
        req = '1;
        rr_m = 0; nresp = 0; cyc = 0; bad_gnt = 0;
        while (nresp < 5 && cyc < 1000) begin
            @(posedge clk); #1; cyc++;
            if (!$onehot0(gnt)) bad_gnt = 1;
            if (rsp_valid) begin
                exp_id = -1;
                for (int j = NREQ - 1; j >= 0; j--)
                    if (pend[(rr_m + j) % NREQ] != 0) exp_id = (rr_m + j) % NREQ;
                total++; if (int'(rsp_id) !== exp_id) $display("FAIL rr_order%0d got=%0d exp=%0d", nresp, rsp_id, exp_id); else passed++;
                if (exp_id >= 0) begin
                    total++; if (int'(rsp_sum) !== ref_sum(oa[exp_id], ob[exp_id])) $display("FAIL rr_sum%0d got=%0d exp=%0d", nresp, rsp_sum, ref_sum(oa[exp_id], ob[exp_id])); else passed++;
                    total++; if (int'(rsp_carry) !== ref_carry(oa[exp_id], ob[exp_id])) $display("FAIL rr_carry%0d got=%0d exp=%0d", nresp, rsp_carry, ref_carry(oa[exp_id], ob[exp_id])); else passed++;
                end
                pend[rsp_id] = 0;
                req[rsp_id] = 1'b0;
                rr_m = (int'(rsp_id) + 1) % NREQ;
                nresp++;
                if (nresp == 2) begin
                    oa[0] = $urandom_range(0, LEN); ob[0] = $urandom_range(0, LEN);
                    op_a[0 +: W] = W'(oa[0]); op_b[0 +: W] = W'(ob[0]);
                    req[0] = 1'b1; pend[0] = 1;
                end
            end
        end
        req = '0;
        total++; if (nresp !== 5) $display("FAIL rr_responses got=%0d exp=5", nresp); else passed++;
        total++; if (bad_gnt !== 0) $display("FAIL rr_gnt_onehot got=%0d exp=0", bad_gnt); else passed++;
    endtask

    task automatic test_reset_mid();
        logic [16:0] outs;
        int cyc, seen, ones, rid, rsum, rcar, en_rsp, acc_rsp, gnt_or, bad_gnt;
        @(posedge clk); #1;
        op_a[1*W +: W] = W'(10); op_b[1*W +: W] = W'(5); req[1] = 1'b1;
        cyc = 0;
        while (!add_rw && cyc < 100) begin @(posedge clk); #1; cyc++; end
        total++; if (add_rw !== 1'b1) $display("FAIL midrst_reach_write got=%0b exp=1", add_rw); else passed++;
        repeat (3) @(posedge clk);
        @(negedge clk); rst_n = 1'b0; #1;
        outs = {gnt, busy, rsp_valid, rsp_id, rsp_sum, rsp_carry, add_en, add_rw, add_a, add_b};
        total++; if (outs !== '0) $display("FAIL midrst_async_zero got=%h exp=0", outs); else passed++;
        req = '0;
        repeat (2) @(posedge clk);
        @(negedge clk); rst_n = 1'b1;
        seen = 0;
        repeat (30) begin @(posedge clk); #1; if (rsp_valid) seen = 1; end
        total++; if (seen !== 0) $display("FAIL midrst_no_rsp got=%0d exp=0", seen); else passed++;
        do_txn(2, 3, 4, cyc, ones, rid, rsum, rcar, en_rsp, acc_rsp, gnt_or, bad_gnt);
        total++; if (rid !== 2) $display("FAIL midrst_next_id got=%0d exp=2", rid); else passed++;
        total++; if (rsum !== 7) $display("FAIL midrst_next_sum got=%0d exp=7", rsum); else passed++;
        total++; if (rcar !== 0) $display("FAIL midrst_next_carry got=%0d exp=0", rcar); else passed++;
    endtask

    task automatic test_back_to_back();
        int id, a, b;
        int cyc, ones, rid, rsum, rcar, en_rsp, acc_rsp, gnt_or, bad_gnt;
        for (int t = 0; t < 100; t++) begin
            id = $urandom_range(0, NREQ - 1);
            a  = $urandom_range(0, LEN);
            b  = $urandom_range(0, LEN);
            do_txn(id, a, b, cyc, ones, rid, rsum, rcar, en_rsp, acc_rsp, gnt_or, bad_gnt);
            total++; if (rid !== id) $display("FAIL b2b%0d_id got=%0d exp=%0d", t, rid, id); else passed++;
            total++; if (rsum !== ref_sum(a, b)) $display("FAIL b2b%0d_sum a=%0d b=%0d got=%0d exp=%0d", t, a, b, rsum, ref_sum(a, b)); else passed++;
            total++; if (rcar !== ref_carry(a, b)) $display("FAIL b2b%0d_carry a=%0d b=%0d got=%0d exp=%0d", t, a, b, rcar, ref_carry(a, b)); else passed++;
            total++; if (cyc !== ref_lat(a, b)) $display("FAIL b2b%0d_latency got=%0d exp=%0d", t, cyc, ref_lat(a, b)); else passed++;
            total++; if (ones !== ref_sum(a, b)) $display("FAIL b2b%0d_dout_ones got=%0d exp=%0d", t, ones, ref_sum(a, b)); else passed++;
            total++; if (en_rsp !== 0) $display("FAIL b2b%0d_en_in_resp got=%0d exp=0", t, en_rsp); else passed++;
            total++; if (acc_rsp !== 0) $display("FAIL b2b%0d_adder_drained got=%0d exp=0", t, acc_rsp); else passed++;
            total++; if (bad_gnt !== 0) $display("FAIL b2b%0d_gnt_onehot got=%0d exp=0", t, bad_gnt); else passed++;
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_vectors();
        test_simultaneous();
        test_reset_mid();
        test_back_to_back();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
